instr_mem_fetch: RTL and testbench

INSTR_MEM_FETCH -- requirements
Module: instr_mem_fetch

---
 rtl/instr_mem_fetch.sv | 89 ++++++++
 tb/tb_instr_mem_fetch.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: byte-programmable instruction memory feeding a 2-entry in-order response FIFO.
// Optional feature macro IMEM_FAULT_CHECK_EN: when defined, misaligned or out-of-range fetches
// return a faulted NOP; when undefined, fetches may be misaligned and byte indices wrap modulo DEPTH.
module instr_mem_fetch #(
  parameter int DEPTH = 64,
  parameter int ADDR_W = 64
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [7:0]        prog_data
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;
  typedef struct packed {
    logic [31:0]       instr;
    logic [ADDR_W-1:0] addr;
    logic              fault;
  } ent_t;
  logic [7:0] mem [DEPTH];
  ent_t head_q, head_d, tail_q, tail_d, fetched;
  logic [1:0] occ_q, occ_d;
  logic push, pop;
  logic [IW-1:0] base;
  logic [31:0] raw;
  logic unused_prog_hi;
  assign req_ready = occ_q != 2'd2;
  assign rsp_valid = occ_q != 2'd0;
  assign rsp_instr = head_q.instr;
  assign rsp_addr  = head_q.addr;
  assign rsp_fault = head_q.fault;
  assign push = req_valid && req_ready && !flush;
  assign pop  = rsp_valid && rsp_ready;
  assign base = req_addr[IW-1:0];
  assign raw  = {mem[base + IW'(3)], mem[base + IW'(2)], mem[base + IW'(1)], mem[base]};
  assign unused_prog_hi = ^prog_addr[ADDR_W-1:IW];
`ifdef IMEM_FAULT_CHECK_EN
  logic bad;
  assign bad = (req_addr[1:0] != 2'b00) || (req_addr > ADDR_W'(DEPTH - 4));
  assign fetched = '{instr: bad ? NOP : raw, addr: req_addr, fault: bad};
`else
  assign fetched = '{instr: raw, addr: req_addr, fault: 1'b0};
`endif
  // FIFO next state: head is always the oldest entry, tail only used at occupancy 2
  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    if (flush) occ_d = 2'd0;
    else if (occ_q == 2'd2) begin
      if (pop) begin
        head_d = tail_q;
        occ_d  = 2'd1;
      end
    end else if (push && (occ_q == 2'd0 || pop)) begin
      head_d = fetched;
      occ_d  = 2'd1;
    end else if (push) begin
      tail_d = fetched;
      occ_d  = 2'd2;
    end else if (pop) occ_d = 2'd0;
  end
  // FIFO state with asynchronous clear; zeroed head keeps rsp_* at 0 during reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
  // Programming port; memory survives reset and same-edge fetches see old bytes
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr[IW-1:0]] <= prog_data;
  end
endmodule

// File: tb/tb_instr_mem_fetch.sv
// tb_instr_mem_fetch: directed scenarios plus randomized traffic checked against a queue-based model.
module tb_instr_mem_fetch;
  localparam int DEPTH = 64;
  localparam int ADDR_W = 64;
  logic clk = 0, reset_n = 0, req_valid = 0, rsp_ready = 0, flush = 0, prog_we = 0;
  logic req_ready, rsp_valid, rsp_fault;
  logic [ADDR_W-1:0] req_addr = '0, prog_addr = '0, rsp_addr;
  logic [31:0] rsp_instr;
  logic [7:0] prog_data = '0;
  int checks = 0, errors = 0;
  typedef struct {
    logic [31:0] instr;
    logic [63:0] addr;
    logic        fault;
  } ent_t;
  ent_t q[$];
  logic [7:0] mem_m [DEPTH];

  instr_mem_fetch #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  function automatic ent_t model_fetch(input logic [63:0] a);
    ent_t e;
    e.addr  = a;
    e.fault = 1'b0;
    for (int k = 0; k < 4; k++) e.instr[8*k +: 8] = mem_m[(a + 64'(k)) % DEPTH];
`ifdef IMEM_FAULT_CHECK_EN
    if ((a % 4) != 0 || ({1'b0, a} + 65'd3) >= 65'(DEPTH)) begin
      e.fault = 1'b1;
      e.instr = 32'h00000013;
    end
`endif
    return e;
  endfunction

  function automatic logic [7:0] pattern(input int i);
    logic [7:0] fixed [4];
    fixed = '{8'h83, 8'h34, 8'h05, 8'h0F};
    return (i < 4) ? fixed[i] : 8'((i * 37 + 11) % 256);
  endfunction

  // Memory model: programmed bytes land after the edge, so same-edge fetches see old data
  always @(posedge clk) if (prog_we) mem_m[prog_addr % DEPTH] <= prog_data;

  // Response queue model in acceptance order
  always @(posedge clk or negedge reset_n) begin : model
    bit acc, pp;
    if (!reset_n) q.delete();
    else begin
      acc = req_valid && (q.size() < 2) && !flush;
      pp  = (q.size() > 0) && rsp_ready;
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (acc) q.push_back(model_fetch(req_addr));
      end
    end
  end

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) if (reset_n) begin
    check("rsp_valid", 64'(rsp_valid), 64'(q.size() != 0));
    check("req_ready", 64'(req_ready), 64'(q.size() < 2));
    if (q.size() != 0) begin
      check("rsp_instr", 64'(rsp_instr), 64'(q[0].instr));
      check("rsp_addr", rsp_addr, q[0].addr);
      check("rsp_fault", 64'(rsp_fault), 64'(q[0].fault));
    end
  end

  initial begin
    #1;
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd1);
    check("reset_rsp_instr", 64'(rsp_instr), 64'd0);
    check("reset_rsp_addr", rsp_addr, 64'd0);
    check("reset_rsp_fault", 64'(rsp_fault), 64'd0);
    @(negedge clk);
    reset_n = 1;
    for (int i = 0; i < DEPTH; i++) begin
      prog_we   = 1;
      prog_addr = 64'(i + DEPTH * $urandom_range(0, 3));
      prog_data = pattern(i);
      @(negedge clk);
    end
    prog_we = 0;
    // basic fetch
    req_valid = 1; req_addr = 0; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    check("fetch0_valid", 64'(rsp_valid), 64'd1);
    check("fetch0_instr", 64'(rsp_instr), 64'h0F053483);
    check("fetch0_fault", 64'(rsp_fault), 64'd0);
    @(negedge clk);
    check("fetch0_popped", 64'(rsp_valid), 64'd0);
    // backpressure and ordering
    rsp_ready = 0; req_valid = 1; req_addr = 0;
    @(negedge clk);
    check("bp_ready_after1", 64'(req_ready), 64'd1);
    req_addr = 4;
    @(negedge clk);
    check("bp_ready_after2", 64'(req_ready), 64'd0);
    req_addr = 8;
    @(negedge clk);
    check("bp_hold_ready", 64'(req_ready), 64'd0);
    check("bp_head0", rsp_addr, 64'd0);
    rsp_ready = 1;
    @(negedge clk);
    check("bp_head4", rsp_addr, 64'd4);
    check("bp_ready_after_pop", 64'(req_ready), 64'd1);
    rsp_ready = 0;
    @(negedge clk);
    check("bp_full_again", 64'(req_ready), 64'd0);
    check("bp_head4_hold", rsp_addr, 64'd4);
    req_valid = 0; rsp_ready = 1;
    @(negedge clk);
    check("bp_head8", rsp_addr, 64'd8);
    @(negedge clk);
    check("bp_empty", 64'(rsp_valid), 64'd0);
    // misaligned and wrapping fetches
    req_valid = 1; req_addr = 2;
    @(negedge clk);
    req_addr = 62;
`ifdef IMEM_FAULT_CHECK_EN
    check("mis2_fault", 64'(rsp_fault), 64'd1);
    check("mis2_instr", 64'(rsp_instr), 64'h00000013);
`else
    check("mis2_fault", 64'(rsp_fault), 64'd0);
    check("mis2_instr", 64'(rsp_instr), 64'hC49F0F05);
`endif
    @(negedge clk);
    req_valid = 0;
`ifdef IMEM_FAULT_CHECK_EN
    check("wrap62_fault", 64'(rsp_fault), 64'd1);
    check("wrap62_instr", 64'(rsp_instr), 64'h00000013);
`else
    check("wrap62_fault", 64'(rsp_fault), 64'd0);
    check("wrap62_instr", 64'(rsp_instr), 64'h34832601);
`endif
    @(negedge clk);
    // flush with two queued and a same-edge request
    rsp_ready = 0; req_valid = 1; req_addr = 0;
    @(negedge clk);
    req_addr = 4;
    @(negedge clk);
    req_addr = 8; flush = 1;
    @(negedge clk);
    flush = 0; req_valid = 0;
    check("flush_valid", 64'(rsp_valid), 64'd0);
    check("flush_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    check("flush_no_late_rsp", 64'(rsp_valid), 64'd0);
    // asynchronous reset mid-cycle with one entry queued
    req_valid = 1; req_addr = 4;
    @(negedge clk);
    req_valid = 0;
    check("pre_reset_valid", 64'(rsp_valid), 64'd1);
    #2 reset_n = 0;
    #1;
    check("async_rst_valid", 64'(rsp_valid), 64'd0);
    check("async_rst_ready", 64'(req_ready), 64'd1);
    check("async_rst_instr", 64'(rsp_instr), 64'd0);
    @(negedge clk);
    reset_n = 1; req_valid = 1; req_addr = 0; rsp_ready = 1;
    @(negedge clk);
    req_valid = 0;
    check("post_rst_valid", 64'(rsp_valid), 64'd1);
    check("post_rst_instr", 64'(rsp_instr), 64'h0F053483);
    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      reset_n   = ($urandom_range(0, 199) != 0);
      req_valid = ($urandom_range(0, 9) < 7);
      case ($urandom_range(0, 9))
        0, 1:    req_addr = {$urandom, $urandom};
        2, 3, 4: req_addr = 64'($urandom_range(0, DEPTH - 1));
        default: req_addr = 64'($urandom_range(0, DEPTH / 4 - 1) * 4);
      endcase
      rsp_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 19) == 0);
      prog_we   = ($urandom_range(0, 4) == 0);
      prog_addr = {$urandom, $urandom};
      prog_data = 8'($urandom);
    end
    @(negedge clk);
    reset_n = 1; req_valid = 0; flush = 0; prog_we = 0; rsp_ready = 1;
    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
